// File: rtl/sextium_pkg.sv
// Shared constants for the Sextium core peripherals.
package sextium_pkg;

    localparam int unsigned BUS_W    = 16;
    localparam int unsigned IO_DEPTH = 8;
    localparam logic [BUS_W-1:0] BUS_Z = 'z;

endpackage

// File: rtl/sextium_io_port_if.sv
// External ready/valid streams of the Sextium I/O port (input side and output side).
interface sextium_io_port_if #(
    parameter int unsigned DATA_W = 16
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sextium_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is taken only when a pop frees a slot on the same edge.
module sextium_sync_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign head    = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/sextium_io_port.sv
// Sextium I/O port: input and output FIFOs between the core's shared bus strobes and
// external ready/valid streams, with sticky underflow/overflow/protocol-error flags.
module sextium_io_port
    import sextium_pkg::*;
#(
    parameter int unsigned DATA_W = BUS_W,
    parameter int unsigned DEPTH  = IO_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] mem_bus,
    input  logic              io_read,
    input  logic              io_write,
    sextium_io_port_if.slave  ext,
    output logic [CNT_W-1:0]  in_count,
    output logic [CNT_W-1:0]  out_count,
    output logic              underflow,
    output logic              overflow,
    output logic              proto_err,
    input  logic              clear_flags
);

    localparam logic [DATA_W-1:0] HIGH_Z = {DATA_W{BUS_Z[0]}};

    logic              rd_eff;
    logic              in_full;
    logic              in_empty;
    logic [DATA_W-1:0] in_head;
    logic              out_full;
    logic              out_empty;
    logic [DATA_W-1:0] out_head;
    logic              out_pop;
    logic              underflow_q;
    logic              overflow_q;
    logic              proto_err_q;
    logic              underflow_set;
    logic              overflow_set;
    logic              proto_err_set;

    // A simultaneous read and write is resolved as a write only.
    assign rd_eff = io_read && !io_write;

    // Gated by reset so the bus is released the moment reset asserts.
    assign mem_bus = (reset && rd_eff) ? in_head : HIGH_Z;

    assign ext.in_ready  = !in_full;
    assign ext.out_valid = !out_empty;
    assign ext.out_data  = out_head;
    assign out_pop       = !out_empty && ext.out_ready;

    sextium_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_in_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (ext.in_valid && ext.in_ready),
        .push_data (ext.in_data),
        .pop       (rd_eff),
        .full      (in_full),
        .empty     (in_empty),
        .count     (in_count),
        .head      (in_head)
    );

    sextium_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (io_write),
        .push_data (mem_bus),
        .pop       (ext.out_ready),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count),
        .head      (out_head)
    );

    assign underflow_set = rd_eff && in_empty;
    assign overflow_set  = io_write && out_full && !out_pop;
    assign proto_err_set = io_read && io_write;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            underflow_q <= underflow_set || (underflow_q && !clear_flags);
            overflow_q  <= overflow_set  || (overflow_q  && !clear_flags);
            proto_err_q <= proto_err_set || (proto_err_q && !clear_flags);
        end
    end

    assign underflow = underflow_q;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sextium_io_port.sv
// Self-checking bench for sextium_io_port: directed scenarios plus a randomized run
// against a queue-based model of the two FIFOs and the sticky flags.
module tb_sextium_io_port;
    import sextium_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 8;
    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    wire  [W-1:0]  mem_bus;
    logic          io_read;
    logic          io_write;
    logic          clear_flags;
    logic          tb_drv;
    logic [W-1:0]  tb_val;
    logic [CW-1:0] in_count;
    logic [CW-1:0] out_count;
    logic          underflow;
    logic          overflow;
    logic          proto_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    assign mem_bus = tb_drv ? tb_val : BUS_Z;

    sextium_io_port_if #(.DATA_W(W)) ext ();

    sextium_io_port #(
        .DATA_W (W),
        .DEPTH  (D),
        .CNT_W  (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_bus     (mem_bus),
        .io_read     (io_read),
        .io_write    (io_write),
        .ext         (ext),
        .in_count    (in_count),
        .out_count   (out_count),
        .underflow   (underflow),
        .overflow    (overflow),
        .proto_err   (proto_err),
        .clear_flags (clear_flags)
    );

    task automatic idle();
        io_read      = 1'b0;
        io_write     = 1'b0;
        clear_flags  = 1'b0;
        tb_drv       = 1'b0;
        tb_val       = '0;
        ext.in_valid = 1'b0;
        ext.in_data  = '0;
        ext.out_ready = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        repeat (3) tick();
        #1;
        total++; if (ext.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", ext.in_ready); end
        total++; if (ext.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", ext.out_valid); end
        total++; if (ext.out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data got=%h exp=0000", ext.out_data); end
        reset = 1'b1;
        tick();
        total++; if (in_count !== 4'd0 || out_count !== 4'd0) begin bad++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", in_count, out_count); end
        total++; if ({underflow, overflow, proto_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {underflow, overflow, proto_err}); end
        // Bus released: a value driven by the bench reads back unchanged.
        tb_drv = 1'b1; tb_val = 16'h5AC3; #1;
        total++; if (mem_bus !== 16'h5AC3) begin bad++; $display("FAIL rst_bus_release got=%h exp=5ac3", mem_bus); end
        tb_drv = 1'b0;
    endtask

    task automatic test_read();
        ext.in_valid = 1'b1; ext.in_data = 16'h1234; tick();
        ext.in_data = 16'hBEEF; tick();
        ext.in_valid = 1'b0;
        total++; if (in_count !== 4'd2) begin bad++; $display("FAIL rd_fill_count got=%0d exp=2", in_count); end
        io_read = 1'b1; #1;
        total++; if (mem_bus !== 16'h1234) begin bad++; $display("FAIL rd_first got=%h exp=1234", mem_bus); end
        tick();
        total++; if (in_count !== 4'd1) begin bad++; $display("FAIL rd_count1 got=%0d exp=1", in_count); end
        total++; if (mem_bus !== 16'hBEEF) begin bad++; $display("FAIL rd_second got=%h exp=beef", mem_bus); end
        tick();
        io_read = 1'b0;
        total++; if (in_count !== 4'd0) begin bad++; $display("FAIL rd_count0 got=%0d exp=0", in_count); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL rd_no_underflow got=%0b exp=0", underflow); end
    endtask

    task automatic test_underflow();
        io_read = 1'b1; #1;
        total++; if (mem_bus !== 16'h0000) begin bad++; $display("FAIL uf_bus got=%h exp=0000", mem_bus); end
        tick();
        io_read = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%0b exp=1", underflow); end
        total++; if (in_count !== 4'd0) begin bad++; $display("FAIL uf_count got=%0d exp=0", in_count); end
        clear_flags = 1'b1; tick();
        clear_flags = 1'b0;
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clear got=%0b exp=0", underflow); end
    endtask

    task automatic test_overflow();
        ext.out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            io_write = 1'b1; tb_drv = 1'b1; tb_val = 16'(i);
            tick();
        end
        io_write = 1'b0; tb_drv = 1'b0;
        total++; if (out_count !== 4'd8) begin bad++; $display("FAIL of_count got=%0d exp=8", out_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL of_flag got=%0b exp=1", overflow); end
        ext.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            total++; if (ext.out_data !== 16'(i)) begin bad++; $display("FAIL of_drain[%0d] got=%h exp=%h", i, ext.out_data, 16'(i)); end
            tick();
        end
        ext.out_ready = 1'b0;
        total++; if (ext.out_valid !== 1'b0) begin bad++; $display("FAIL of_no_ninth got=%0b exp=0", ext.out_valid); end
        clear_flags = 1'b1; tick();
        clear_flags = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL of_clear got=%0b exp=0", overflow); end
    endtask

    task automatic test_full_pop_write();
        logic [W-1:0] last;
        for (int i = 0; i < 8; i++) begin
            io_write = 1'b1; tb_drv = 1'b1; tb_val = 16'h0010 + 16'(i);
            tick();
        end
        tb_val = 16'h00AA; ext.out_ready = 1'b1;
        tick();
        io_write = 1'b0; tb_drv = 1'b0; ext.out_ready = 1'b0;
        total++; if (out_count !== 4'd8) begin bad++; $display("FAIL fpw_count got=%0d exp=8", out_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpw_overflow got=%0b exp=0", overflow); end
        total++; if (ext.out_data !== 16'h0011) begin bad++; $display("FAIL fpw_head got=%h exp=0011", ext.out_data); end
        last = '0;
        ext.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1; last = ext.out_data;
            tick();
        end
        ext.out_ready = 1'b0;
        total++; if (last !== 16'h00AA) begin bad++; $display("FAIL fpw_last got=%h exp=00aa", last); end
    endtask

    task automatic test_proto_and_reset();
        ext.in_valid = 1'b1; ext.in_data = 16'h7777; tick();
        ext.in_valid = 1'b0;
        io_read = 1'b1; io_write = 1'b1; tb_drv = 1'b1; tb_val = 16'h3C3C; #1;
        total++; if (mem_bus !== 16'h3C3C) begin bad++; $display("FAIL pe_bus got=%h exp=3c3c", mem_bus); end
        tick();
        io_read = 1'b0; io_write = 1'b0; tb_drv = 1'b0;
        total++; if (in_count !== 4'd1) begin bad++; $display("FAIL pe_in_count got=%0d exp=1", in_count); end
        total++; if (out_count !== 4'd1 || ext.out_data !== 16'h3C3C) begin bad++; $display("FAIL pe_out got=%0d/%h exp=1/3c3c", out_count, ext.out_data); end
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL pe_flag got=%0b exp=1", proto_err); end
        ext.in_valid = 1'b1; ext.in_data = 16'h4444; tick();
        ext.in_valid = 1'b0;
        io_read = 1'b1; #1;
        reset = 1'b0; #1;
        total++; if (in_count !== 4'd0 || out_count !== 4'd0) begin bad++; $display("FAIL mid_rst_counts got=%0d/%0d exp=0/0", in_count, out_count); end
        total++; if (ext.out_valid !== 1'b0 || proto_err !== 1'b0) begin bad++; $display("FAIL mid_rst_state got=%0b/%0b exp=0/0", ext.out_valid, proto_err); end
        tb_drv = 1'b1; tb_val = 16'h0F0F; #1;
        total++; if (mem_bus !== 16'h0F0F) begin bad++; $display("FAIL mid_rst_bus got=%h exp=0f0f", mem_bus); end
        idle();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] in_q[$];
        logic [W-1:0] out_q[$];
        logic m_uf, m_of, m_pe;
        int p_in, p_rd, p_wr, p_or;
        m_uf = 1'b0; m_of = 1'b0; m_pe = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic         rd, wr, ext_pop, in_push, in_pop, wr_ok;
            logic [W-1:0] exp_bus, exp_head;
            int           nin, nout;
            case (n / 150)
                0:       begin p_in = 80; p_rd = 20; p_wr = 70; p_or = 20; end
                1:       begin p_in = 20; p_rd = 70; p_wr = 20; p_or = 80; end
                2:       begin p_in = 50; p_rd = 45; p_wr = 45; p_or = 50; end
                default: begin p_in = 90; p_rd = 10; p_wr = 90; p_or = 10; end
            endcase
            ext.in_valid  = ($urandom_range(99) < p_in);
            ext.in_data   = 16'($urandom);
            io_read       = ($urandom_range(99) < p_rd);
            io_write      = ($urandom_range(99) < p_wr);
            ext.out_ready = ($urandom_range(99) < p_or);
            clear_flags   = ($urandom_range(9) == 0);
            rd            = io_read && !io_write;
            tb_drv        = io_write || (!rd && $urandom_range(3) == 0);
            tb_val        = 16'($urandom);
            #1;
            nin  = in_q.size();
            nout = out_q.size();
            exp_head = (nout > 0) ? out_q[0] : '0;
            total++; if (in_count !== CW'(nin)) begin bad++; $display("FAIL rnd_in_count n=%0d got=%0d exp=%0d", n, in_count, nin); end
            total++; if (out_count !== CW'(nout)) begin bad++; $display("FAIL rnd_out_count n=%0d got=%0d exp=%0d", n, out_count, nout); end
            total++; if (ext.in_ready !== (nin < D)) begin bad++; $display("FAIL rnd_in_ready n=%0d got=%0b", n, ext.in_ready); end
            total++; if (ext.out_valid !== (nout > 0)) begin bad++; $display("FAIL rnd_out_valid n=%0d got=%0b", n, ext.out_valid); end
            total++; if (ext.out_data !== exp_head) begin bad++; $display("FAIL rnd_out_data n=%0d got=%h exp=%h", n, ext.out_data, exp_head); end
            total++; if ({underflow, overflow, proto_err} !== {m_uf, m_of, m_pe}) begin bad++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {underflow, overflow, proto_err}, {m_uf, m_of, m_pe}); end
            if (rd || tb_drv) begin
                exp_bus = rd ? ((nin > 0) ? in_q[0] : '0) : tb_val;
                total++; if (mem_bus !== exp_bus) begin bad++; $display("FAIL rnd_bus n=%0d got=%h exp=%h", n, mem_bus, exp_bus); end
            end
            wr      = io_write;
            ext_pop = (nout > 0) && ext.out_ready;
            in_push = ext.in_valid && (nin < D);
            in_pop  = rd && (nin > 0);
            wr_ok   = wr && ((nout < D) || ext_pop);
            m_uf = (rd && nin == 0) || (m_uf && !clear_flags);
            m_of = (wr && !wr_ok) || (m_of && !clear_flags);
            m_pe = (io_read && io_write) || (m_pe && !clear_flags);
            if (in_pop) void'(in_q.pop_front());
            if (in_push) in_q.push_back(ext.in_data);
            if (ext_pop) void'(out_q.pop_front());
            if (wr_ok) out_q.push_back(tb_val);
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_read();
        test_underflow();
        test_overflow();
        test_full_pop_write();
        test_proto_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sextium_io_port.md
Name: sextium_io_port

Overview:
I/O peripheral for the Sextium core, sharing the 16-bit bidirectional data bus with memory and responding only to the core's io_read/io_write strobes. It buffers incoming words from the external world in an input FIFO and outgoing words from the core in an output FIFO. Both external sides use ready/valid handshakes. The core has no wait line, so underflow and overflow are reported through sticky flags rather than stalls.

Parameters:
DATA_W, 16, bus/word width
DEPTH, 8, entries per FIFO (power of two, >=2)
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_bus  inout  DATA_W  shared data bus; driven only during io_read
io_read  input  1  core strobe: pop input FIFO onto mem_bus
io_write  input  1  core strobe: push mem_bus into output FIFO
in_data  input  DATA_W  external input word
in_valid  input  1  external input word valid
in_ready  output  1  input FIFO can accept
out_data  output  DATA_W  head of output FIFO
out_valid  output  1  output FIFO non-empty
out_ready  input  1  external consumer accepts out_data
in_count  output  CNT_W  input FIFO occupancy
out_count  output  CNT_W  output FIFO occupancy
underflow  output  1  sticky: io_read while input FIFO empty
overflow  output  1  sticky: io_write dropped (output full)
proto_err  output  1  sticky: io_read and io_write both high
clear_flags  input  1  synchronous clear of the three sticky flags

Behaviour:
- Reset (reset=0, async): both FIFOs empty, pointers 0, counts 0, flags 0. mem_bus is high-Z, in_ready=1, out_valid=0, out_data=0.
- mem_bus drive: combinational, equal to in-FIFO head when io_read=1, io_write=0 and FIFO non-empty. It is all-zero when io_read=1 and the FIFO is empty. Otherwise high-Z.
- Pop: each rising edge with io_read=1, io_write=0 and in_count>0 pops one entry. Strobes are level-sampled per edge, so a strobe held N cycles pops N entries.
- io_read with empty FIFO: no pointer change; underflow<=1.
- Push from core: each rising edge with io_write=1 writes mem_bus into the output FIFO. Accepted iff out_count<DEPTH, or an external pop (out_valid&&out_ready) occurs on the same edge. Otherwise the write is dropped and overflow<=1.
- io_read and io_write both high: treated as io_write only. mem_bus is not driven, no pop, proto_err<=1.
- External input: push on the edge where in_valid&&in_ready. in_ready = (in_count<DEPTH), registered-state only, with no combinational path from io_read. Push and pop on the same edge: count unchanged, both take effect.
- External output: out_data/out_valid reflect the FIFO head with no combinational path from io_write. A word written at edge k is visible at out_data after edge k (first-word latency 1 cycle). Pop on out_valid&&out_ready.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts saturate logically at 0..DEPTH and never overflow.
- Flags: set has priority over clear_flags in the same cycle. Otherwise clear_flags forces them to 0.
- Reset asserted mid-operation: all FIFO contents are discarded immediately and mem_bus releases asynchronously.

Decomposition:
- Shared package sextium_pkg: DATA_W default (16), bus Z constant, IO_DEPTH default.
- Sub-module sextium_sync_fifo (push/pop/full/empty/count/head, async active-low reset). It is instantiated twice: the input-side instance has push=external and pop=io_read; the output-side instance is the reverse. The top level holds the tristate, the strobe decode and the flags.

Test Plan:
- Reset held low, then released: mem_bus=Z, in_ready=1, out_valid=0, counts=0, flags=0.
- External pushes 0x1234, 0xBEEF. One io_read cycle: mem_bus=0x1234, then in_count=1. A second io_read cycle: mem_bus=0xBEEF, then in_count=0.
- io_read with empty input FIFO: mem_bus=0x0000 and underflow=1. Pulse clear_flags: underflow=0.
- out_ready=0, 9 io_write cycles with 1..9: out_count=8 and overflow=1. Then out_ready=1: out_data sequence 1..8 and 9 is absent.
- Output FIFO full, io_write 0x00AA on the same edge as an external pop: write accepted, out_count stays 8, overflow stays 0.
- io_read and io_write together: mem_bus not driven, in_count unchanged, out FIFO gains the word, proto_err=1. A reset pulse mid-stream empties both FIFOs.
